// File: rtl/c0_read_arbiter.sv
// Round-robin arbiter sharing one CCI-P c0 read channel among NUM_REQ clients,
// with per-client in-flight limits and tag-based response routing.
module c0_read_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*42-1:0]   req_addr,
    input  logic [NUM_REQ*12-1:0]   req_mdata,
    input  logic                    c0TxAlmFull,
    output logic                    tx_valid,
    output logic [41:0]             tx_addr,
    output logic [15:0]             tx_mdata,
    input  logic                    rx_rspValid,
    input  logic [15:0]             rx_mdata,
    input  logic [511:0]            rx_data,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [11:0]             rsp_mdata,
    output logic [511:0]            rsp_data,
    output logic [NUM_REQ*16-1:0]   outstanding,
    output logic                    idle,
    output logic                    err_bad_id
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = PTR_W + 1;
    localparam logic [15:0] MAX_CNT = 16'(MAX_OUTSTANDING);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        cnt_q [NUM_REQ];
    logic [15:0]        cnt_d [NUM_REQ];
    logic               tx_valid_q;
    logic [41:0]        tx_addr_q;
    logic [15:0]        tx_mdata_q;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [11:0]        rsp_mdata_q;
    logic [511:0]       rsp_data_q;
    logic               idle_q, idle_d;
    logic               err_q, err_d;

    logic [41:0]        addr_arr  [NUM_REQ];
    logic [11:0]        mdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_hit;
    logic [PTR_W-1:0]   grant_idx;
    logic [CW-1:0]      cand;
    logic               grant_any;
    logic [3:0]         rx_id;
    logic               id_ok;
    logic               rsp_ok;
    logic               underflow;
    logic               all_zero;

    assign rx_id  = rx_mdata[15:12];
    assign id_ok  = ({1'b0, rx_id} < 5'(NUM_REQ));
    assign rsp_ok = rx_rspValid && id_ok;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_client
        assign addr_arr[gi]             = req_addr[gi*42 +: 42];
        assign mdata_arr[gi]            = req_mdata[gi*12 +: 12];
        assign eligible[gi]             = req_valid[gi] && (cnt_q[gi] < MAX_CNT) && !c0TxAlmFull;
        assign rsp_hit[gi]              = rsp_ok && (rx_id == 4'(gi));
        assign outstanding[gi*16 +: 16] = cnt_q[gi];
    end

    // Search starts at rr_ptr and wraps; the first eligible client wins.
    always_comb begin : arbitrate
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // NOTE: blocking assignments here, so later iterations see the
            // updated cand/grant_any within the same evaluation.
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
            if (!grant_any && eligible[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_comb begin : next_state
        rr_ptr_d = rr_ptr_q;
        if (grant_any)
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

        underflow = 1'b0;
        all_zero  = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !rsp_hit[i]) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end else if (rsp_hit[i] && !grant[i]) begin
                // A response with nothing in flight is a protocol error, not a wrap.
                if (cnt_q[i] == '0) underflow = 1'b1;
                else                cnt_d[i] = cnt_q[i] - 16'd1;
            end
            if (cnt_d[i] != '0) all_zero = 1'b0;
        end

        rsp_valid_d = rsp_hit;
        err_d       = err_q || (rx_rspValid && !id_ok) || underflow;
        idle_d      = all_zero && !grant_any;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q    <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            rsp_valid_q <= '0;
            rsp_mdata_q <= '0;
            idle_q      <= 1'b1;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tx_valid_q  <= grant_any;
            rsp_valid_q <= rsp_valid_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
            if (grant_any) begin
                tx_addr_q  <= addr_arr[grant_idx];
                tx_mdata_q <= {4'(grant_idx), mdata_arr[grant_idx]};
            end
            if (rsp_ok) rsp_mdata_q <= rx_mdata[11:0];
        end
    end

    // NOTE: the 512-bit data register is deliberately left without reset; it is
    // only meaningful alongside rsp_valid, which is reset.
    always_ff @(posedge clk) begin
        if (rsp_ok) rsp_data_q <= rx_data;
    end

    assign req_ready  = grant;
    assign tx_valid   = tx_valid_q;
    assign tx_addr    = tx_addr_q;
    assign tx_mdata   = tx_mdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_mdata  = rsp_mdata_q;
    assign rsp_data   = rsp_data_q;
    assign idle       = idle_q;
    assign err_bad_id = err_q;

endmodule

// File: tb/tb_c0_read_arbiter.sv
// Self-checking bench for c0_read_arbiter: directed scenarios plus a randomized
// phase, all compared against a cycle-level behavioural model of the arbiter.
module tb_c0_read_arbiter;

    localparam int N    = 2;
    localparam int MAXO = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*42-1:0]   req_addr = '0;
    logic [N*12-1:0]   req_mdata = '0;
    logic              c0TxAlmFull = 1'b0;
    logic              tx_valid;
    logic [41:0]       tx_addr;
    logic [15:0]       tx_mdata;
    logic              rx_rspValid = 1'b0;
    logic [15:0]       rx_mdata = '0;
    logic [511:0]      rx_data = '0;
    logic [N-1:0]      rsp_valid;
    logic [11:0]       rsp_mdata;
    logic [511:0]      rsp_data;
    logic [N*16-1:0]   outstanding;
    logic              idle;
    logic              err_bad_id;

    always #5 clk = ~clk;

    c0_read_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_mdata(req_mdata),
        .c0TxAlmFull(c0TxAlmFull),
        .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_mdata(tx_mdata),
        .rx_rspValid(rx_rspValid), .rx_mdata(rx_mdata), .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
        .outstanding(outstanding), .idle(idle), .err_bad_id(err_bad_id)
    );

    // Reference model state
    int           m_ptr;
    int           m_cnt [N];
    bit           m_err, m_idle, m_tx_valid;
    logic [41:0]  m_tx_addr;
    logic [15:0]  m_tx_mdata;
    logic [N-1:0] m_rsp_valid;
    logic [11:0]  m_rsp_mdata;
    logic [511:0] m_rsp_data;
    logic [15:0]  inflight [$];

    // Snapshots of DUT outputs taken at the last negedge
    logic [N-1:0]    s_ready, s_rsp_valid;
    logic [11:0]     s_rsp_mdata;
    logic [15:0]     s_tx_mdata;
    logic [N*16-1:0] s_outstanding;
    logic            s_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_err = 0; m_idle = 1; m_tx_valid = 0; m_rsp_valid = '0;
        inflight.delete();
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i] && m_cnt[i] < MAXO && !c0TxAlmFull) return i;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        int id;
        bit ok;
        bit zero;
        id = int'(rx_mdata[15:12]);
        ok = rx_rspValid && (id < N);
        m_rsp_valid = '0;
        if (ok) begin
            m_rsp_valid[id] = 1'b1;
            m_rsp_mdata = rx_mdata[11:0];
            m_rsp_data  = rx_data;
        end
        if (rx_rspValid && !ok) m_err = 1;
        for (int i = 0; i < N; i++) begin
            bit inc = (g == i);
            bit dec = ok && (id == i);
            if (inc && !dec) m_cnt[i]++;
            else if (dec && !inc) begin
                if (m_cnt[i] == 0) m_err = 1;
                else m_cnt[i]--;
            end
        end
        m_tx_valid = (g >= 0);
        if (g >= 0) begin
            m_tx_addr  = req_addr[g*42 +: 42];
            m_tx_mdata = {4'(g), req_mdata[g*12 +: 12]};
            inflight.push_back(m_tx_mdata);
            m_ptr = (g + 1) % N;
        end
        zero = 1;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) zero = 0;
        m_idle = zero && !m_tx_valid;
    endtask

    // One clock: compare every output against the model at negedge, then advance.
    task automatic tick();
        int g;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        s_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_mdata = rsp_mdata;
        s_tx_mdata = tx_mdata; s_outstanding = outstanding; s_err = err_bad_id;
        check("req_ready", req_ready, exp_ready);
        check("tx_valid", tx_valid, m_tx_valid);
        if (m_tx_valid) begin
            check("tx_addr", tx_addr, m_tx_addr);
            check("tx_mdata", tx_mdata, m_tx_mdata);
        end
        check("rsp_valid", rsp_valid, m_rsp_valid);
        if (m_rsp_valid != '0) begin
            check("rsp_mdata", rsp_mdata, m_rsp_mdata);
            check("rsp_data", rsp_data, m_rsp_data);
        end
        for (int i = 0; i < N; i++)
            check($sformatf("outstanding[%0d]", i), outstanding[i*16 +: 16], 16'(m_cnt[i]));
        check("idle", idle, m_idle);
        check("err_bad_id", err_bad_id, m_err);
        model_update(g);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rsp(input int idx);
        rx_rspValid = 1'b1;
        rx_mdata    = inflight[idx];
        rx_data     = rand512();
        inflight.delete(idx);
    endtask

    task automatic randomize_req();
        req_addr  = (N*42)'({$urandom(), $urandom(), $urandom()});
        req_mdata = (N*12)'($urandom());
    endtask

    task automatic drain();
        int guard = 0;
        req_valid = '0;
        c0TxAlmFull = 1'b0;
        while (inflight.size() > 0 && guard < 1000) begin
            send_rsp($urandom_range(0, inflight.size() - 1));
            tick();
            guard++;
        end
        rx_rspValid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int grants;
        int idx;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_outstanding", outstanding, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        tick();
        check("rst_err", s_err, 1'b0);

        // Both clients valid for 6 cycles: strict alternation starting at 0
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            randomize_req();
            tick();
            check("alt_grant", s_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) check("alt_tx_id", s_tx_mdata[15:12], 4'((k - 1) % 2));
        end
        req_valid = '0;
        tick();
        check("alt_tx_id_last", s_tx_mdata[15:12], 4'd1);
        drain();

        // Client 1 alone hits the in-flight limit, one response frees a slot
        req_valid = 2'b10;
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            req_addr  = (N*42)'({$urandom(), $urandom(), $urandom()});
            req_mdata = {12'h005, 12'h0aa};
            tick();
            if (s_ready[1]) grants++;
        end
        check("limit_grants", grants, 4);
        check("limit_ready", s_ready, 2'b00);
        check("limit_count", s_outstanding[31:16], 16'd4);
        req_valid = '0;
        idx = -1;
        for (int q = 0; q < inflight.size(); q++) if (idx < 0 && inflight[q] == 16'h1005) idx = q;
        if (idx >= 0) send_rsp(idx);
        tick();
        rx_rspValid = 1'b0;
        req_valid = 2'b10;
        tick();
        check("limit_rsp_valid", s_rsp_valid, 2'b10);
        check("limit_rsp_mdata", s_rsp_mdata, 12'h005);
        check("limit_count_dec", s_outstanding[31:16], 16'd3);
        check("limit_regrant", s_ready, 2'b10);
        drain();

        // Almost-full blocks all grants; pointer is at client 0 afterwards
        req_valid = 2'b11;
        c0TxAlmFull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            randomize_req();
            tick();
            check("almfull_block", s_ready, 2'b00);
        end
        c0TxAlmFull = 1'b0;
        tick();
        check("almfull_release", s_ready, 2'b01);
        drain();

        // Grant and response for client 0 in the same cycle at count 2
        req_valid = 2'b01;
        randomize_req();
        tick();
        tick();
        idx = -1;
        for (int q = 0; q < inflight.size(); q++) if (idx < 0 && inflight[q][15:12] == 4'd0) idx = q;
        if (idx >= 0) send_rsp(idx);
        tick();
        check("simul_pre", s_outstanding[15:0], 16'd2);
        rx_rspValid = 1'b0;
        req_valid = '0;
        tick();
        check("simul_net", s_outstanding[15:0], 16'd2);
        drain();

        // Bad response ID is dropped and the error is sticky
        rx_rspValid = 1'b1;
        rx_mdata = 16'h7000;
        rx_data = rand512();
        tick();
        rx_rspValid = 1'b0;
        tick();
        check("badid_rsp_valid", s_rsp_valid, 2'b00);
        check("badid_err", s_err, 1'b1);
        repeat (3) begin
            tick();
            check("badid_sticky", s_err, 1'b1);
        end

        // Randomized traffic with out-of-order responses
        for (int k = 0; k < 1500; k++) begin
            req_valid = N'($urandom_range(0, 3));
            c0TxAlmFull = ($urandom_range(0, 4) == 0);
            randomize_req();
            rx_rspValid = 1'b0;
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                send_rsp($urandom_range(0, inflight.size() - 1));
            end else if ($urandom_range(0, 49) == 0) begin
                rx_rspValid = 1'b1;
                rx_mdata = {4'($urandom_range(N, 15)), 12'($urandom())};
                rx_data = rand512();
            end
            tick();
        end
        drain();

        // Asynchronous reset with lines in flight, then a stale response
        req_valid = 2'b11;
        repeat (3) begin
            randomize_req();
            tick();
        end
        req_valid = '0;
        #2;
        resetn = 1'b0;
        #1;
        check("async_tx_valid", tx_valid, 1'b0);
        check("async_outstanding", outstanding, '0);
        check("async_idle", idle, 1'b1);
        check("async_err", err_bad_id, 1'b0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        rx_rspValid = 1'b1;
        rx_mdata = 16'h0abc;
        rx_data = rand512();
        tick();
        rx_rspValid = 1'b0;
        tick();
        check("stale_rsp_valid", s_rsp_valid, 2'b01);
        check("stale_rsp_mdata", s_rsp_mdata, 12'habc);
        check("stale_count", s_outstanding[15:0], 16'd0);
        check("stale_err", s_err, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c0_read_arbiter.md
Name: c0_read_arbiter

Overview:
- Shares one CCI-P c0 read-request channel and its response stream among NUM_REQ read clients (prefetch engine, model loader, etc.).
- Round-robin arbitration; each client is limited to MAX_OUTSTANDING in-flight lines.
- Client ID is tagged into mdata[15:12] on each request; each response is routed back to the originating client by that tag.
- Sits between the client engines and the shell c0 TX/RX ports.

Parameters:
- NUM_REQ, 2, number of clients, range 1..16.
- MAX_OUTSTANDING, 64, per-client in-flight line limit, range 1..65535.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  client i has a read request
- req_ready  out  NUM_REQ  request i accepted this cycle
- req_addr  in  NUM_REQ*42  client i cache-line address, slice [42i+41:42i]
- req_mdata  in  NUM_REQ*12  client i tag, slice [12i+11:12i]
- c0TxAlmFull  in  1  shell c0 almost-full
- tx_valid  out  1  c0 read request valid
- tx_addr  out  42  c0 request address
- tx_mdata  out  16  {id[3:0], client mdata[11:0]}
- rx_rspValid  in  1  c0 response valid, read response only
- rx_mdata  in  16  response mdata
- rx_data  in  512  response data
- rsp_valid  out  NUM_REQ  response for client i
- rsp_mdata  out  12  response tag, shared by all clients
- rsp_data  out  512  response data, shared by all clients
- outstanding  out  NUM_REQ*16  per-client in-flight count
- idle  out  1  all in-flight counts zero and tx_valid low
- err_bad_id  out  1  sticky error flag

Behaviour:
- Reset values: tx_valid, rsp_valid, err_bad_id and all outstanding counters are 0. idle=1. Pointer rr_ptr=0.
- Eligibility: client i is eligible when req_valid[i] && outstanding[i] < MAX_OUTSTANDING && !c0TxAlmFull.
- Grant: combinational, one-hot. Pick the first eligible client at or after rr_ptr, wrapping modulo NUM_REQ. req_ready = grant.
- No eligible client: no grant and rr_ptr holds.
- Pointer update: on a grant to client g, rr_ptr <= (g+1) mod NUM_REQ on the next edge.
- Request output is registered, so latency is 1 cycle. In the cycle after a grant to g: tx_valid=1, tx_addr=req_addr[g], tx_mdata={g[3:0], req_mdata[g]}. In all other cycles tx_valid=0; tx_addr and tx_mdata hold their last values.
- Backpressure: c0TxAlmFull blocks all grants in that cycle. A request already registered still issues. The shell tolerates this because of almost-full slack.
- Response routing is registered, also 1 cycle latency. On rx_rspValid with id=rx_mdata[15:12] < NUM_REQ, the next cycle has rsp_valid[id]=1, rsp_mdata=rx_mdata[11:0], rsp_data=rx_data. Clients cannot stall responses.
- Bad ID: id >= NUM_REQ. The response is dropped (no rsp_valid) and err_bad_id is set.
- Counter update for client i:
  - +1 on grant[i].
  - -1 on an accepted response for i.
  - Both in the same cycle: net unchanged.
  - A decrement at 0 saturates at 0 and sets err_bad_id.
  - An increment at MAX_OUTSTANDING cannot occur, because eligibility prevents it.
- err_bad_id clears only on reset.
- idle is registered: (all counters == 0) && !tx_valid, from the next-state values.
- Reset mid-operation clears all state immediately, asynchronously. Stale responses arriving after reset:
  - Valid ID with counter 0: routed to the client, counter saturates, err_bad_id set.
  - Bad ID: dropped, err_bad_id set.
- Single client (NUM_REQ=1): grant = eligibility and rr_ptr stays 0.
- The block does not reorder: responses go out in shell arrival order.

Test Plan:
- NUM_REQ=2, both req_valid held high for 6 cycles, no almfull -> grants alternate 0,1,0,1,0,1. Each tx_valid is one cycle after its grant. tx_mdata[15:12] alternates 0,1.
- Client 1 only, MAX_OUTSTANDING=4, no responses -> exactly 4 grants, then req_ready[1]=0 with outstanding[1]=4. One response with mdata=0x1005 -> next cycle rsp_valid=2'b10, rsp_mdata=0x005. Outstanding drops to 3 and one more grant follows.
- c0TxAlmFull high for 3 cycles while both clients valid -> no req_ready for those 3 cycles. Deassert -> grant goes to client rr_ptr.
- Grant to client 0 and a response with id 0 in the same cycle at outstanding[0]=2 -> outstanding[0] remains 2.
- rx_rspValid with rx_mdata=0x7000 and NUM_REQ=2 -> no rsp_valid and err_bad_id=1, which persists until resetn low.
- Assert resetn=0 with 3 lines in flight -> tx_valid=0, counters=0, idle=1 asynchronously. A later response with id 0 -> routed, counter stays 0, err_bad_id=1.
